fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 130 +++++++++++++
 tb/tb_fp_add_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin issue arbiter for an external pipelined FP adder
// Optional counters stat_issued/stat_stall are built when FPADD_ARB_STATS_EN is defined.
module fp_add_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 7
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 en,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   opa,
   input  logic [32*NREQ-1:0]   opb,
   output logic [NREQ-1:0]      gnt,
   output logic [31:0]          add_dataa,
   output logic [31:0]          add_datab,
   input  logic [31:0]          add_result,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_data,
`ifdef FPADD_ARB_STATS_EN
   output logic [31:0]          stat_issued,
   output logic [31:0]          stat_stall,
`endif
   output logic                 busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t        r_state;
   logic [IW-1:0] r_rr;
   logic [LAT:0]  r_vld;
   logic [IW-1:0] r_tag [LAT+1];
   logic [31:0]   r_dataa;
   logic [31:0]   r_datab;

   logic          w_found;
   logic [IW-1:0] w_win;
   logic [IW:0]   w_idx;
   logic          w_can_issue;
   logic          w_acc;
   logic          w_any_req;
   logic          w_empty;

   // Scan from the round-robin pointer, wrapping modulo NREQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = {1'b0, r_rr} + (IW+1)'(k);
         if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
         if (!w_found && req[w_idx[IW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[IW-1:0];
         end
      end
   end

   assign w_any_req   = |req;
   assign w_empty     = (r_vld == '0);
   assign w_can_issue = nreset && en && ((r_state == S_IDLE) || (r_state == S_RUN));
   assign w_acc       = w_can_issue && w_found;

   always_comb begin
      gnt = '0;
      if (w_acc) gnt[w_win] = 1'b1;
   end

   always_comb begin
      rsp_valid = '0;
      if (r_vld[LAT]) rsp_valid[r_tag[LAT]] = 1'b1;
   end

   assign rsp_data  = add_result;
   assign add_dataa = r_dataa;
   assign add_datab = r_datab;
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_vld   <= '0;
         r_dataa <= '0;
         r_datab <= '0;
         for (int i = 0; i <= LAT; i++) r_tag[i] <= '0;
      end else begin
         r_vld    <= {r_vld[LAT-1:0], w_acc};
         r_tag[0] <= w_win;
         for (int i = 1; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
         if (w_acc) begin
            r_dataa <= opa[32*int'(w_win) +: 32];
            r_datab <= opb[32*int'(w_win) +: 32];
            r_rr    <= (w_win == IW'(NREQ-1)) ? '0 : w_win + IW'(1);
         end
         case (r_state)
            S_IDLE:  if (en && w_any_req) r_state <= S_RUN;
            S_RUN: begin
               if (!en)                       r_state <= S_DRAIN;
               else if (!w_any_req && w_empty) r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (en && w_any_req) r_state <= S_RUN;
               else if (w_empty)    r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FPADD_ARB_STATS_EN
   logic [31:0] r_stat_issued;
   logic [31:0] r_stat_stall;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_stat_issued <= '0;
         r_stat_stall  <= '0;
      end else begin
         if (w_acc)                 r_stat_issued <= r_stat_issued + 32'd1;
         if (w_any_req && !w_acc)   r_stat_stall  <= r_stat_stall + 32'd1;
      end
   end

   assign stat_issued = r_stat_issued;
   assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter
// Includes a LAT-deep adder model handling positive normal operands.
module tb_fp_add_arbiter;

   localparam int NREQ = 4;
   localparam int LAT  = 7;

   logic         clk = 1'b0;
   logic         nreset;
   logic         en;
   logic [3:0]   req;
   logic [127:0] opa;
   logic [127:0] opb;
   logic [3:0]   gnt;
   logic [31:0]  add_dataa;
   logic [31:0]  add_datab;
   logic [31:0]  add_result;
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_data;
   logic         busy;
`ifdef FPADD_ARB_STATS_EN
   logic [31:0]  stat_issued;
   logic [31:0]  stat_stall;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] r_pipe [LAT];
   logic [31:0] exp_res [4];

   always #5 clk = ~clk;

   fp_add_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .en         (en),
      .req        (req),
      .opa        (opa),
      .opb        (opb),
      .gnt        (gnt),
      .add_dataa  (add_dataa),
      .add_datab  (add_datab),
      .add_result (add_result),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
`ifdef FPADD_ARB_STATS_EN
      .stat_issued(stat_issued),
      .stat_stall (stat_stall),
`endif
      .busy       (busy)
   );

   function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  e;
      logic [24:0] ma;
      logic [24:0] mb;
      logic [24:0] s;
      if (a_in[30:23] >= b_in[30:23]) begin a = a_in; b = b_in; end
      else begin a = b_in; b = a_in; end
      e  = a[30:23];
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]} >> (a[30:23] - b[30:23]);
      s  = ma + mb;
      if (s[24]) begin
         s = s >> 1;
         e = e + 8'd1;
      end
      return {1'b0, e, s[22:0]};
   endfunction

   always @(posedge clk) begin
      r_pipe[0] <= fadd(add_dataa, add_datab);
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
   end
   assign add_result = r_pipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         next_cycle();
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy), 32'h0);
   endtask

   initial begin
      logic [3:0] acc;
      logic       ball;

      exp_res[0] = 32'h40400000;
      exp_res[1] = 32'h40800000;
      exp_res[2] = 32'h40A00000;
      exp_res[3] = 32'h40C00000;
      opa = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
      opb = {4{32'h40000000}};

      // reset with live requests: grant must stay masked
      nreset = 1'b0;
      en     = 1'b1;
      req    = 4'b1111;
      next_cycle();
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rsp", 32'(rsp_valid), 32'h0);
      chk("rst_dataa", add_dataa, 32'h0);
      chk("rst_datab", add_datab, 32'h0);

      // single request, 1.0 + 2.0
      next_cycle();
      nreset = 1'b1;
      req    = 4'b0001;
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'h1);
      next_cycle();
      req = 4'b0000;
      @(negedge clk);
      chk("single_dataa", add_dataa, 32'h3F800000);
      chk("single_datab", add_datab, 32'h40000000);
      chk("single_busy", 32'(busy), 32'h1);
      acc = rsp_valid;
      for (int k = 2; k <= 7; k++) begin
         next_cycle();
         @(negedge clk);
         acc = acc | rsp_valid;
      end
      next_cycle();
      @(negedge clk);
      chk("single_early", 32'(acc), 32'h0);
      chk("single_rsp", 32'(rsp_valid), 32'h1);
      chk("single_data", rsp_data, 32'h40400000);
      next_cycle();
      @(negedge clk);
      chk("single_rsp_end", 32'(rsp_valid), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("single_idle", 32'(busy), 32'h0);

      // fairness, back-to-back, overlapping issue and return
      next_cycle();
      nreset = 1'b0;
      @(negedge clk);
      next_cycle();
      nreset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) next_cycle();
         req = (k < 12) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         if (k < 12) chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
         if (k >= 1 && k <= 12) chk("rr_dataa", add_dataa, opa[32*((k-1)%4) +: 32]);
         if (k >= 8) begin
            chk("rr_rsp", 32'(rsp_valid), 32'(1 << ((k-8) % 4)));
            chk("rr_data", rsp_data, exp_res[(k-8) % 4]);
         end
      end
      wait_idle("rr_idle");

      // enable drop after two acceptances
      next_cycle();
      req = 4'b0011;
      en  = 1'b1;
      @(negedge clk);
      chk("drop_gnt0", 32'(gnt), 32'h1);
      acc  = 4'b0000;
      ball = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         next_cycle();
         en = (k < 2);
         @(negedge clk);
         if (k == 1) chk("drop_gnt1", 32'(gnt), 32'h2);
         else        acc = acc | gnt;
         if (k <= 10) ball = ball & busy;
         if (k == 8)  chk("drop_rsp0", 32'(rsp_valid), 32'h1);
         if (k == 9)  chk("drop_rsp1", 32'(rsp_valid), 32'h2);
         if (k == 11) chk("drop_idle", 32'(busy), 32'h0);
      end
      chk("drop_no_gnt", 32'(acc), 32'h0);
      chk("drop_busy_held", 32'(ball), 32'h1);

      // reset mid-flight (pointer starts at 2)
      next_cycle();
      en  = 1'b1;
      req = 4'b1111;
      @(negedge clk);
      chk("mid_gnt0", 32'(gnt), 32'h4);
      next_cycle();
      @(negedge clk);
      chk("mid_gnt1", 32'(gnt), 32'h8);
      next_cycle();
      @(negedge clk);
      chk("mid_gnt2", 32'(gnt), 32'h1);
      next_cycle();
      nreset = 1'b0;
      @(negedge clk);
      chk("mid_rst_gnt", 32'(gnt), 32'h0);
      acc = rsp_valid;
      next_cycle();
      nreset = 1'b1;
      req    = 4'b1001;
      @(negedge clk);
      chk("mid_post_gnt", 32'(gnt), 32'h1);
      acc = acc | rsp_valid;
      for (int k = 5; k <= 11; k++) begin
         next_cycle();
         req = 4'b0000;
         @(negedge clk);
         acc = acc | rsp_valid;
      end
      next_cycle();
      @(negedge clk);
      chk("mid_discard", 32'(acc), 32'h0);
      chk("mid_post_rsp", 32'(rsp_valid), 32'h1);
      chk("mid_post_data", rsp_data, exp_res[0]);
      wait_idle("mid_idle");

      // pointer wrap 3 -> 0 -> 1
      next_cycle();
      req = 4'b0100;
      @(negedge clk);
      chk("wrap_set", 32'(gnt), 32'h4);
      next_cycle();
      req = 4'b1001;
      @(negedge clk);
      chk("wrap_gnt3", 32'(gnt), 32'h8);
      next_cycle();
      @(negedge clk);
      chk("wrap_gnt0", 32'(gnt), 32'h1);
      next_cycle();
      req = 4'b1111;
      @(negedge clk);
      chk("wrap_rr1", 32'(gnt), 32'h2);
      next_cycle();
      req = 4'b0000;
      @(negedge clk);
      wait_idle("wrap_idle");

`ifdef FPADD_ARB_STATS_EN
      next_cycle();
      nreset = 1'b0;
      @(negedge clk);
      chk("stat_rst", stat_issued, 32'h0);
      next_cycle();
      nreset = 1'b1;
      en     = 1'b1;
      req    = 4'b0011;
      @(negedge clk);
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         @(negedge clk);
      end
      next_cycle();
      en = 1'b0;
      @(negedge clk);
      chk("stat_issued4", stat_issued, 32'd4);
      chk("stat_stall0", stat_stall, 32'd0);
      for (int k = 5; k <= 6; k++) begin
         next_cycle();
         @(negedge clk);
      end
      next_cycle();
      req = 4'b0000;
      en  = 1'b1;
      @(negedge clk);
      chk("stat_stall3", stat_stall, 32'd3);
      chk("stat_issued_hold", stat_issued, 32'd4);
      wait_idle("stat_idle");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
